apu_triangle_frontend: RTL and testbench
========================================

Name: apu_triangle_frontend

Overview:
- CPU-side front end for the triangle channel. Decodes CPU register writes ($4008, $400A, $400B, $4017) and holds the three triangle register bytes the channel consumes.
- Emits a one-cycle length/linear reload strobe on every $400B write.
- Runs the APU frame sequencer that produces the quarter-frame and half-frame clocks. These clock the channel's linear counter and length counter.
- Sits between the CPU bus decoder and the triangle channel; its outputs wire directly to the channel's register inputs.

Parameters:
- CLK_DIV, 1, clk cycles per frame-sequencer tick (>=1); raise it for real hardware, keep it at 1 for simulation.
- SEQ_W, 15, frame-sequencer counter width; must hold 18641.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising clk
- wr_en  in  1  one-cycle CPU write strobe
- wr_addr  in  5  register offset from $4000 (e.g. 5'h08 = $4008)
- wr_data  in  8  write data
- irq_ack  in  1  one-cycle acknowledge (a $4015 read), clears frame_irq
- reg4008  out  8  {control flag, 7-bit linear counter reload}
- reg400A  out  8  timer low
- reg400B  out  8  {5-bit length index, timer[10:8]}
- reload  out  1  pulses the cycle after a $400B write
- quarter_frame  out  1  one-cycle tick
- half_frame  out  1  one-cycle tick
- frame_irq  out  1  level interrupt request

Behaviour:
- Reset values:
  - reg4008/reg400A/reg400B = 0; reload = 0.
  - quarter_frame = half_frame = frame_irq = 0.
  - mode = 0 (4-step); irq_inhibit = 0.
  - sequencer count = 0; divider = 0.
- Register writes:
  - When wr_en is high and wr_addr matches, the register updates on that clk edge.
  - Outputs are visible the next cycle (latency 1).
  - Non-matching addresses are ignored.
- reload: registered. High exactly 1 cycle, the cycle after the $400B write edge. Back-to-back $400B writes give back-to-back pulses.
- Divider: counts 0..CLK_DIV-1. Emits a tick on wrap. The sequencer advances only on ticks.
- Sequencer, 4-step mode (mode = 0):
  - Quarter events at count 3729, 7457, 11186, 14915.
  - Half events at 7457 and 14915.
  - At 14915: count wraps to 0; frame_irq is set if irq_inhibit = 0.
- Sequencer, 5-step mode (mode = 1):
  - Quarter events at 3729, 7457, 11186, 18641.
  - Half events at 7457 and 18641.
  - Wraps at 18641; never sets frame_irq.
- Event outputs: quarter_frame and half_frame are registered and high for exactly 1 clk in the cycle following the tick that reached the event count.
- $4017 write: mode <= wr_data[7], irq_inhibit <= wr_data[6]; sequencer count and divider are cleared.
  - If wr_data[6] = 1, frame_irq clears next cycle.
  - If wr_data[7] = 1, quarter_frame and half_frame both pulse next cycle (immediate clock).
- Simultaneous events:
  - $4017 write in the same cycle as a sequencer event: the write wins; the event is suppressed except for the immediate clock of mode 1.
  - irq_ack in the same cycle as IRQ set: set wins.
- frame_irq holds until irq_ack, an inhibit write, or reset.
- Reset mid-operation: every state element returns to its reset value on the next edge; pending pulses are dropped.

Optional Feature:
- APU_FRAME_IRQ_EN
  - Defined: frame_irq flop, irq_inhibit handling and irq_ack behave as above.
  - Undefined: frame_irq is tied to 0, irq_ack is ignored, and no IRQ flop is synthesized. wr_data[6] on a $4017 write has no effect.

Decomposition:
- Shared package apu_pkg:
  - Address constants ADDR_4008, ADDR_400A, ADDR_400B, ADDR_4017.
  - Step constants STEP1=3729, STEP2=7457, STEP3=11186, STEP4_4=14915, STEP4_5=18641.
  - Mode enum {SEQ_4STEP, SEQ_5STEP}.
- Sub-module apu_frame_sequencer (divider, counter, event decode, IRQ). The top level keeps the register decode and the reload strobe.

Test Plan:
- Write $4008=0xC8 at cycle 10 -> reg4008=0xC8 from cycle 11; reg400A and reg400B unchanged (0); reload stays 0.
- Write $400B=0x2B -> reg400B=0x2B the next cycle and reload=1 for exactly one cycle; two consecutive writes -> two consecutive reload pulses.
- CLK_DIV=1, reset, then free run in 4-step mode -> quarter_frame at ticks 3729/7457/11186/14915, half_frame at 7457/14915, frame_irq rises after 14915; irq_ack clears it.
- Write $4017=0x80 -> quarter_frame and half_frame both pulse the next cycle; the next events occur 3729 ticks later; no frame_irq after 18641.
- Write $4017=0x40 while frame_irq=1 -> frame_irq clears; a full 4-step period then elapses with no IRQ. With APU_FRAME_IRQ_EN undefined, frame_irq stays 0 throughout.
- Assert reset at count 9000 with frame_irq=1 and registers loaded -> all outputs 0 next cycle; after release, the first quarter_frame comes 3729 ticks later.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared constants and types for the APU triangle front end.
//   - CPU register offsets (relative to $4000) decoded by the front end
//   - frame-sequencer step counts for the 4-step and 5-step modes
//   - sequencer mode enum and the CPU write payload struct
package apu_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_4008 = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_400A = 5'h0A;
  localparam logic [ADDR_W-1:0] ADDR_400B = 5'h0B;
  localparam logic [ADDR_W-1:0] ADDR_4017 = 5'h17;

  localparam int unsigned STEP1   = 3729;
  localparam int unsigned STEP2   = 7457;
  localparam int unsigned STEP3   = 11186;
  localparam int unsigned STEP4_4 = 14915;
  localparam int unsigned STEP4_5 = 18641;

  typedef enum logic {
    SEQ_4STEP = 1'b0,
    SEQ_5STEP = 1'b1
  } seq_mode_e;

  // One CPU bus write as seen by the decoder
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cpu_wr_t;

  // True when a write strobe targets the given register offset
  function automatic logic addr_hit(input logic en, input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] target);
    return en && (addr == target);
  endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: clock divider, frame-sequencer counter, quarter/half
// frame event decode and the frame interrupt flag.
// Optional feature: APU_FRAME_IRQ_EN (defined -> frame IRQ flop, inhibit and
// acknowledge are built; undefined -> o_frame_irq is tied low).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_wr_4017         one-cycle $4017 write strobe
//   i_mode            wr_data[7] of the $4017 write (1 = 5-step)
//   i_inhibit         wr_data[6] of the $4017 write (IRQ inhibit)
//   i_irq_ack         one-cycle IRQ acknowledge
//   o_quarter_frame   one-cycle quarter-frame clock
//   o_half_frame      one-cycle half-frame clock
//   o_frame_irq       level frame interrupt request
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned SEQ_W   = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wr_4017,
  input  logic i_mode,
  input  logic i_inhibit,
  input  logic i_irq_ack,
  output logic o_quarter_frame,
  output logic o_half_frame,
  output logic o_frame_irq
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [SEQ_W-1:0] CNT_S1   = SEQ_W'(STEP1);
  localparam logic [SEQ_W-1:0] CNT_S2   = SEQ_W'(STEP2);
  localparam logic [SEQ_W-1:0] CNT_S3   = SEQ_W'(STEP3);
  localparam logic [SEQ_W-1:0] CNT_S4_4 = SEQ_W'(STEP4_4);
  localparam logic [SEQ_W-1:0] CNT_S4_5 = SEQ_W'(STEP4_5);

  logic [DIV_W-1:0] r_div;
  logic [SEQ_W-1:0] r_cnt;
  seq_mode_e        r_mode;
  logic             r_quarter;
  logic             r_half;

  logic             w_tick;
  logic [SEQ_W-1:0] w_cnt_nxt;
  logic [SEQ_W-1:0] w_cnt_last;
  logic             w_wrap;
  logic             w_half_evt;
  logic             w_qtr_evt;

  // Event decode on the count the current tick is about to reach
  always_comb begin
    w_tick     = (r_div == DIV_LAST);
    w_cnt_nxt  = r_cnt + SEQ_W'(1);
    w_cnt_last = (r_mode == SEQ_5STEP) ? CNT_S4_5 : CNT_S4_4;
    w_wrap     = w_tick && (w_cnt_nxt == w_cnt_last);
    w_half_evt = w_tick && ((w_cnt_nxt == CNT_S2) || (w_cnt_nxt == w_cnt_last));
    w_qtr_evt  = w_half_evt ||
                 (w_tick && ((w_cnt_nxt == CNT_S1) || (w_cnt_nxt == CNT_S3)));
  end

  // Divider, counter and event pulses; a $4017 write overrides any event
  // except the immediate clock requested by selecting 5-step mode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_mode    <= SEQ_4STEP;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
    end else if (i_wr_4017) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_mode    <= seq_mode_e'(i_mode);
      r_quarter <= i_mode;
      r_half    <= i_mode;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : w_cnt_nxt;
      end
      r_quarter <= w_qtr_evt;
      r_half    <= w_half_evt;
    end
  end

  assign o_quarter_frame = r_quarter;
  assign o_half_frame    = r_half;

`ifdef APU_FRAME_IRQ_EN
  logic r_irq_inhibit;
  logic r_frame_irq;
  logic w_irq_set;

  assign w_irq_set = w_wrap && (r_mode == SEQ_4STEP) && !r_irq_inhibit;

  // IRQ flag: set beats acknowledge; an inhibit write clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_inhibit <= 1'b0;
      r_frame_irq   <= 1'b0;
    end else if (i_wr_4017) begin
      r_irq_inhibit <= i_inhibit;
      if (i_inhibit || i_irq_ack) begin
        r_frame_irq <= 1'b0;
      end
    end else if (w_irq_set) begin
      r_frame_irq <= 1'b1;
    end else if (i_irq_ack) begin
      r_frame_irq <= 1'b0;
    end
  end

  assign o_frame_irq = r_frame_irq;
`else
  // IRQ inputs have no function in this build
  logic [1:0] w_unused_irq;
  assign w_unused_irq = {i_inhibit, i_irq_ack};
  assign o_frame_irq  = 1'b0;
`endif

endmodule

// File: rtl/apu_triangle_frontend.sv
// apu_triangle_frontend: CPU-side front end of the triangle channel.
// Decodes $4008/$400A/$400B/$4017 writes, holds the triangle register bytes,
// strobes reload after every $400B write and hosts the frame sequencer.
// Optional feature: APU_FRAME_IRQ_EN (frame IRQ; tied low when undefined).
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   wr_en           one-cycle CPU write strobe
//   wr_addr         register offset from $4000
//   wr_data         write data
//   irq_ack         one-cycle acknowledge, clears frame_irq
//   reg4008         {control flag, linear counter reload}
//   reg400A         timer low
//   reg400B         {length index, timer[10:8]}
//   reload          one-cycle pulse after a $400B write
//   quarter_frame   one-cycle quarter-frame clock
//   half_frame      one-cycle half-frame clock
//   frame_irq       level frame interrupt request
module apu_triangle_frontend
  import apu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned SEQ_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              irq_ack,
  output logic [DATA_W-1:0] reg4008,
  output logic [DATA_W-1:0] reg400A,
  output logic [DATA_W-1:0] reg400B,
  output logic              reload,
  output logic              quarter_frame,
  output logic              half_frame,
  output logic              frame_irq
);

  cpu_wr_t           w_wr;
  logic              w_wr_4008;
  logic              w_wr_400a;
  logic              w_wr_400b;
  logic              w_wr_4017;

  logic [DATA_W-1:0] r_reg4008;
  logic [DATA_W-1:0] r_reg400a;
  logic [DATA_W-1:0] r_reg400b;
  logic              r_reload;

  // Address decode
  assign w_wr      = '{addr: wr_addr, data: wr_data};
  assign w_wr_4008 = addr_hit(wr_en, w_wr.addr, ADDR_4008);
  assign w_wr_400a = addr_hit(wr_en, w_wr.addr, ADDR_400A);
  assign w_wr_400b = addr_hit(wr_en, w_wr.addr, ADDR_400B);
  assign w_wr_4017 = addr_hit(wr_en, w_wr.addr, ADDR_4017);

  // Triangle register bytes and the reload strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg4008 <= '0;
      r_reg400a <= '0;
      r_reg400b <= '0;
      r_reload  <= 1'b0;
    end else begin
      if (w_wr_4008) begin
        r_reg4008 <= w_wr.data;
      end
      if (w_wr_400a) begin
        r_reg400a <= w_wr.data;
      end
      if (w_wr_400b) begin
        r_reg400b <= w_wr.data;
      end
      r_reload <= w_wr_400b;
    end
  end

  apu_frame_sequencer #(
    .CLK_DIV (CLK_DIV),
    .SEQ_W   (SEQ_W)
  ) u_frame_seq (
    .clk             (clk),
    .reset           (reset),
    .i_wr_4017       (w_wr_4017),
    .i_mode          (w_wr.data[7]),
    .i_inhibit       (w_wr.data[6]),
    .i_irq_ack       (irq_ack),
    .o_quarter_frame (quarter_frame),
    .o_half_frame    (half_frame),
    .o_frame_irq     (frame_irq)
  );

  assign reg4008 = r_reg4008;
  assign reg400A = r_reg400a;
  assign reg400B = r_reg400b;
  assign reload  = r_reload;

endmodule

// File: tb/tb_apu_triangle_frontend.sv
// tb_apu_triangle_frontend: scoreboard bench for apu_triangle_frontend.
// Expected pulse cycles for quarter_frame, half_frame and reload are queued
// when stimulus is applied and matched against pulses seen on the outputs.
module tb_apu_triangle_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       irq_ack;
  logic [7:0] reg4008;
  logic [7:0] reg400A;
  logic [7:0] reg400B;
  logic       reload;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;

`ifdef APU_FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam int R0  = 2;
  localparam int R1  = R0 + 14915 + 9000;
  localparam int W1  = R1 + 14920;
  localparam int W2  = W1 + 14920;
  localparam int W3  = W2 + 14920;
  localparam int END = W3 + 18650;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int q_exp[$];
  int h_exp[$];
  int r_exp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apu_triangle_frontend #(.CLK_DIV(1), .SEQ_W(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .irq_ack       (irq_ack),
    .reg4008       (reg4008),
    .reg400A       (reg400A),
    .reg400B       (reg400B),
    .reload        (reload),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .frame_irq     (frame_irq)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Queue quarter/half pulse cycles for a sequencer run starting at base
  task automatic push_seq(input int base, input bit five, input int limit);
    int last;
    last = five ? 18641 : 14915;
    for (int b = base; b < limit; b += last) begin
      if (b + 3729 < limit)  q_exp.push_back(b + 3729);
      if (b + 7457 < limit)  begin q_exp.push_back(b + 7457); h_exp.push_back(b + 7457); end
      if (b + 11186 < limit) q_exp.push_back(b + 11186);
      if (b + last < limit)  begin q_exp.push_back(b + last); h_exp.push_back(b + last); end
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int n);
    wait_to(n);
    @(negedge clk);
  endtask

  // Write captured by the rising edge that starts cycle n
  task automatic do_write(input int n, input logic [4:0] a, input logic [7:0] d);
    wait_to(n - 1);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    wait_to(n - 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse_ack(input int n);
    wait_to(n - 1);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_4008"}, 32'(reg4008), 0);
    check_val({tag, "_400A"}, 32'(reg400A), 0);
    check_val({tag, "_400B"}, 32'(reg400B), 0);
    check_val({tag, "_reload"}, 32'(reload), 0);
    check_val({tag, "_qf"}, 32'(quarter_frame), 0);
    check_val({tag, "_hf"}, 32'(half_frame), 0);
    check_val({tag, "_irq"}, 32'(frame_irq), 0);
  endtask

  // Pulse monitor: every pulse must match the oldest queued cycle, and no
  // queued cycle may pass unseen
  always @(negedge clk) begin
    if (cyc >= R0) begin
      if (quarter_frame) begin
        if (q_exp.size() == 0) check_val("qf_extra", 32'(cyc), 0);
        else check_val("qf_cycle", 32'(cyc), 32'(q_exp.pop_front()));
      end
      if (q_exp.size() != 0 && q_exp[0] < cyc) check_val("qf_missed", 32'(cyc), 32'(q_exp.pop_front()));
      if (half_frame) begin
        if (h_exp.size() == 0) check_val("hf_extra", 32'(cyc), 0);
        else check_val("hf_cycle", 32'(cyc), 32'(h_exp.pop_front()));
      end
      if (h_exp.size() != 0 && h_exp[0] < cyc) check_val("hf_missed", 32'(cyc), 32'(h_exp.pop_front()));
      if (reload) begin
        if (r_exp.size() == 0) check_val("reload_extra", 32'(cyc), 0);
        else check_val("reload_cycle", 32'(cyc), 32'(r_exp.pop_front()));
      end
      if (r_exp.size() != 0 && r_exp[0] < cyc) check_val("reload_missed", 32'(cyc), 32'(r_exp.pop_front()));
    end
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    irq_ack = 1'b0;

    // Power-on reset, then a free-running 4-step sequence
    do_reset(R0);
    push_seq(R0, 1'b0, R1);
    @(negedge clk);
    check_all_zero("por");

    // Register decode
    do_write(10, 5'h08, 8'hC8);
    @(negedge clk);
    check_val("w4008", 32'(reg4008), 32'h0C8);
    check_val("w4008_400A", 32'(reg400A), 0);
    check_val("w4008_400B", 32'(reg400B), 0);
    check_val("w4008_reload", 32'(reload), 0);
    do_write(12, 5'h09, 8'hFF);
    do_write(13, 5'h0C, 8'hFF);
    @(negedge clk);
    check_val("nomatch_4008", 32'(reg4008), 32'h0C8);
    check_val("nomatch_400A", 32'(reg400A), 0);
    check_val("nomatch_400B", 32'(reg400B), 0);
    do_write(14, 5'h0A, 8'h5A);
    @(negedge clk);
    check_val("w400A", 32'(reg400A), 32'h05A);
    r_exp.push_back(16);
    do_write(16, 5'h0B, 8'h2B);
    @(negedge clk);
    check_val("w400B", 32'(reg400B), 32'h02B);
    check_val("w400B_reload", 32'(reload), 1);
    r_exp.push_back(18);
    r_exp.push_back(19);
    do_write(18, 5'h0B, 8'h11);
    do_write(19, 5'h0B, 8'hF8);
    @(negedge clk);
    check_val("b2b_400B", 32'(reg400B), 32'h0F8);
    check_val("b2b_reload", 32'(reload), 1);
    sample_at(20);
    check_val("reload_end", 32'(reload), 0);

    // Frame IRQ at the end of the first 4-step period
    sample_at(R0 + 14914);
    check_val("irq_before", 32'(frame_irq), 0);
    sample_at(R0 + 14915);
    check_val("irq_set", 32'(frame_irq), 32'(IRQ_ON));

    // Reset mid-period with IRQ pending and registers loaded
    sample_at(R1 - 1);
    check_val("irq_hold", 32'(frame_irq), 32'(IRQ_ON));
    check_val("pre_rst_4008", 32'(reg4008), 32'h0C8);
    do_reset(R1);
    push_seq(R1, 1'b0, W1);
    @(negedge clk);
    check_all_zero("midrst");

    // Inhibit write clears the IRQ and keeps it off for a full period
    sample_at(R1 + 14915);
    check_val("irq_set2", 32'(frame_irq), 32'(IRQ_ON));
    do_write(W1, 5'h17, 8'h40);
    push_seq(W1, 1'b0, W2);
    @(negedge clk);
    check_val("inh_clear", 32'(frame_irq), 0);
    sample_at(W1 + 14916);
    check_val("inh_no_irq", 32'(frame_irq), 0);

    // Re-enable IRQ, then acknowledge it
    do_write(W2, 5'h17, 8'h00);
    push_seq(W2, 1'b0, W3);
    sample_at(W2 + 14915);
    check_val("irq_set3", 32'(frame_irq), 32'(IRQ_ON));
    pulse_ack(W2 + 14918);
    @(negedge clk);
    check_val("irq_ack", 32'(frame_irq), 0);

    // 5-step mode: immediate clock, then a full period with no IRQ
    q_exp.push_back(W3);
    h_exp.push_back(W3);
    do_write(W3, 5'h17, 8'h80);
    push_seq(W3, 1'b1, END);
    @(negedge clk);
    check_val("imm_qf", 32'(quarter_frame), 1);
    check_val("imm_hf", 32'(half_frame), 1);
    sample_at(W3 + 18642);
    check_val("five_no_irq", 32'(frame_irq), 0);

    sample_at(END);
    check_val("qf_left", 32'(q_exp.size()), 0);
    check_val("hf_left", 32'(h_exp.size()), 0);
    check_val("reload_left", 32'(r_exp.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
